// File: rtl/hls_frame_ctrl.sv
// Frame-level sequencer for an HLS pixel block: debounced mode switch, frame-synchronous
// mode hand-off, single-outstanding start/ready/done handshake, drop and pixel accounting.
//
// state | meaning
// IDLE  | waiting for a pixel strobe; mode updates apply here
// START | ap_start asserted, waiting for ap_ready
// WAIT  | accepted by the block, waiting for ap_done
module hls_frame_ctrl #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode_sw,
  input  logic        vsync_i,
  input  logic        da_i_en,
  input  logic        ap_ready,
  input  logic        ap_done,
  input  logic        ovf_clr,
  output logic        ap_start,
  output logic [7:0]  mode_o,
  output logic        busy_o,
  output logic        ovf_o,
  output logic [15:0] drop_cnt_o,
  output logic [21:0] frame_pix_o
);

  localparam logic [7:0] DEB_RELOAD = 8'(DEB_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_sw_s1, r_sw_s2, r_sw_last, r_mode_deb, r_mode;
  logic [7:0]  r_deb_cnt;
  logic        r_vsync_d, r_mode_pend, r_ovf;
  logic [15:0] r_drop_cnt;
  logic [21:0] r_pix_cnt, r_frame_pix;
  logic        w_vs_rise, w_drop, w_done_acc, w_to_idle;

  assign w_vs_rise = vsync_i & ~r_vsync_d;
  assign w_drop    = da_i_en & (r_state != IDLE);
  assign w_to_idle = (r_state != IDLE) & (w_state_nxt == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_done_acc  = 1'b0;
    case (r_state)
      IDLE:  if (da_i_en) w_state_nxt = START;
      START: if (ap_ready) begin
               w_state_nxt = ap_done ? IDLE : WAIT;
               w_done_acc  = ap_done;
             end
      WAIT:  if (ap_done) begin
               w_state_nxt = IDLE;
               w_done_acc  = 1'b1;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Debounce counts down from the moment the synchronized value changes; terminal count loads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1    <= 2'b00;
      r_sw_s2    <= 2'b00;
      r_sw_last  <= 2'b00;
      r_mode_deb <= 2'b00;
      r_deb_cnt  <= 8'd0;
      r_vsync_d  <= 1'b0;
    end else begin
      r_sw_s1   <= mode_sw;
      r_sw_s2   <= r_sw_s1;
      r_sw_last <= r_sw_s2;
      r_vsync_d <= vsync_i;
      if (r_sw_s2 == r_mode_deb || r_sw_s2 != r_sw_last) r_deb_cnt <= DEB_RELOAD;
      else if (r_deb_cnt == 8'd0)                         r_mode_deb <= r_sw_s2;
      else                                                r_deb_cnt <= r_deb_cnt - 8'd1;
    end
  end

  // Mode only changes while no transaction is in flight; a mid-transaction frame start defers it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= 2'b00;
      r_mode_pend <= 1'b0;
    end else if (w_vs_rise && r_state == IDLE) begin
      r_mode <= r_mode_deb;
    end else if (w_to_idle && (r_mode_pend || w_vs_rise)) begin
      r_mode      <= r_mode_deb;
      r_mode_pend <= 1'b0;
    end else if (w_vs_rise) begin
      r_mode_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (ovf_clr) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= {15'd0, w_drop};
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_cnt   <= 22'd0;
      r_frame_pix <= 22'd0;
    end else if (w_vs_rise) begin
      r_frame_pix <= (w_done_acc && r_pix_cnt != '1) ? r_pix_cnt + 22'd1 : r_pix_cnt;
      r_pix_cnt   <= 22'd0;
    end else if (w_done_acc && r_pix_cnt != '1) begin
      r_pix_cnt <= r_pix_cnt + 22'd1;
    end
  end

  assign ap_start    = (r_state == START);
  assign busy_o      = (r_state != IDLE);
  assign mode_o      = {6'b0, r_mode};
  assign ovf_o       = r_ovf;
  assign drop_cnt_o  = r_drop_cnt;
  assign frame_pix_o = r_frame_pix;

endmodule
